// File: rtl/min_pkg.sv
// Shared types and constants for the minimum-sample buffer: handshake FSM states and sizes.
package min_pkg;

    localparam int unsigned SAMPLE_W  = 8;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned CNT_W     = 4;

    // Handshakes on both sides: dav_ is active low; rfd high = ready, low = acknowledge.
    typedef enum logic {
        I_IDLE,
        I_ACK
    } in_state_e;

    typedef enum logic [1:0] {
        O_IDLE,
        O_LOAD,
        O_VALID,
        O_REL
    } out_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Small power-of-two sample FIFO with wrap-around pointers and a separate occupancy counter.
module sample_fifo
    import min_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic                clock,
    input  logic                reset_,
    input  logic                push,
    input  logic                pop,
    input  logic [SAMPLE_W-1:0] wdata,
    output logic [SAMPLE_W-1:0] head_c,
    output logic                full_c,
    output logic                empty_c,
    output logic [LVL_W-1:0]    level
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; contents are only visible through the level-qualified head.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign empty_c = (level_q == '0);
    assign level   = level_q;

endmodule

// File: rtl/min_sample_buffer.sv
// Buffers upstream minimum samples in a FIFO, forwards them downstream, and flags runs of low samples.
module min_sample_buffer
    import min_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEF,
    parameter  int unsigned N_LOW = 3,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset_,
    input  logic                dav_,
    input  logic [SAMPLE_W-1:0] min,
    output logic                rfd,
    input  logic [SAMPLE_W-1:0] thr,
    output logic                dav_out_,
    output logic [SAMPLE_W-1:0] data_out,
    input  logic                rfd_out,
    output logic [LVL_W-1:0]    level,
    output logic                alarm
);

    in_state_e           in_state_q, in_state_d;
    out_state_e          out_state_q, out_state_d;
    logic                rfd_q, rfd_d;
    logic                dav_out_q, dav_out_d;
    logic [SAMPLE_W-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                alarm_q, alarm_d;
    logic                push, pop;
    logic [SAMPLE_W-1:0] head_c;
    logic                full_c, empty_c;

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_  (reset_),
        .push    (push),
        .pop     (pop),
        .wdata   (min),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .level   (level)
    );

    // Upstream accept FSM and low-sample run counter.
    always_comb begin
        in_state_d = in_state_q;
        rfd_d      = rfd_q;
        cnt_d      = cnt_q;
        alarm_d    = alarm_q;
        push       = 1'b0;
        case (in_state_q)
            I_IDLE: begin
                if (!dav_ && !full_c) begin
                    push       = 1'b1;
                    rfd_d      = 1'b0;
                    in_state_d = I_ACK;
                    if (min < thr) begin
                        if (cnt_q < CNT_W'(N_LOW)) cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(N_LOW)) alarm_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        alarm_d = 1'b0;
                    end
                end
            end
            I_ACK: begin
                if (dav_) begin
                    rfd_d      = 1'b1;
                    in_state_d = I_IDLE;
                end
            end
            default: in_state_d = I_IDLE;
        endcase
    end

    // Downstream presentation FSM.
    always_comb begin
        out_state_d = out_state_q;
        dav_out_d   = dav_out_q;
        data_out_d  = data_out_q;
        pop         = 1'b0;
        case (out_state_q)
            O_IDLE: begin
                if (!empty_c && rfd_out) begin
                    data_out_d  = head_c;
                    pop         = 1'b1;
                    out_state_d = O_LOAD;
                end
            end
            O_LOAD: begin
                dav_out_d   = 1'b0;
                out_state_d = O_VALID;
            end
            O_VALID: begin
                if (!rfd_out) begin
                    dav_out_d   = 1'b1;
                    out_state_d = O_REL;
                end
            end
            O_REL: begin
                if (rfd_out) out_state_d = O_IDLE;
            end
            default: out_state_d = O_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            in_state_q  <= I_IDLE;
            out_state_q <= O_IDLE;
            rfd_q       <= 1'b1;
            dav_out_q   <= 1'b1;
            data_out_q  <= '0;
            cnt_q       <= '0;
            alarm_q     <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            rfd_q       <= rfd_d;
            dav_out_q   <= dav_out_d;
            data_out_q  <= data_out_d;
            cnt_q       <= cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    assign rfd      = rfd_q;
    assign dav_out_ = dav_out_q;
    assign data_out = data_out_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_min_sample_buffer.sv
// Directed bench for min_sample_buffer: handshakes, backpressure, same-edge push/pop, alarm and reset.
module tb_min_sample_buffer;

    logic       clock;
    logic       reset_;
    logic       dav_;
    logic [7:0] min;
    logic       rfd;
    logic [7:0] thr;
    logic       dav_out_;
    logic [7:0] data_out;
    logic       rfd_out;
    logic [2:0] level;
    logic       alarm;

    int n_assert = 0;
    int n_fail   = 0;

    min_sample_buffer #(.DEPTH(4), .N_LOW(3)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .dav_     (dav_),
        .min      (min),
        .rfd      (rfd),
        .thr      (thr),
        .dav_out_ (dav_out_),
        .data_out (data_out),
        .rfd_out  (rfd_out),
        .level    (level),
        .alarm    (alarm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one sample upstream, wait for the acknowledge, then release dav_.
    task automatic send(input logic [7:0] v, input logic exp_alarm, input string tag);
        min  = v;
        dav_ = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rfd == 1'b0) break;
        end
        chk({tag, " accept"}, 32'(rfd), 32'(0));
        chk({tag, " alarm"}, 32'(alarm), 32'(exp_alarm));
        dav_ = 1'b1;
        step();
    endtask

    // Act as a one-cycle responsive sink for one sample.
    task automatic recv(input logic [7:0] v, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (dav_out_ == 1'b0) break;
            step();
        end
        chk({tag, " dav_out_"}, 32'(dav_out_), 32'(0));
        chk({tag, " data"}, 32'(data_out), 32'(v));
        rfd_out = 1'b0;
        step();
        chk({tag, " release"}, 32'(dav_out_), 32'(1));
        rfd_out = 1'b1;
        step();
    endtask

    initial begin
        reset_  = 1'b0;
        dav_    = 1'b1;
        min     = 8'h00;
        thr     = 8'h40;
        rfd_out = 1'b1;
        step();
        chk("reset rfd", 32'(rfd), 32'(1));
        chk("reset dav_out_", 32'(dav_out_), 32'(1));
        chk("reset data_out", 32'(data_out), 32'(0));
        chk("reset level", 32'(level), 32'(0));
        chk("reset alarm", 32'(alarm), 32'(0));
        step();
        reset_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle dav_out_", 32'(dav_out_), 32'(1));
        end

        // Single pass-through with exact latencies.
        min  = 8'h5A;
        dav_ = 1'b0;
        step();
        chk("pt accept rfd", 32'(rfd), 32'(0));
        chk("pt accept level", 32'(level), 32'(1));
        chk("pt accept dav_out_", 32'(dav_out_), 32'(1));
        dav_ = 1'b1;
        step();
        chk("pt rfd back", 32'(rfd), 32'(1));
        chk("pt data_out", 32'(data_out), 32'(8'h5A));
        chk("pt level popped", 32'(level), 32'(0));
        chk("pt dav_out_ not yet", 32'(dav_out_), 32'(1));
        step();
        chk("pt dav_out_ low", 32'(dav_out_), 32'(0));
        rfd_out = 1'b0;
        step();
        chk("pt dav_out_ high", 32'(dav_out_), 32'(1));
        chk("pt data held", 32'(data_out), 32'(8'h5A));
        rfd_out = 1'b1;
        step();
        step();
        chk("pt quiet", 32'(dav_out_), 32'(1));
        chk("pt alarm", 32'(alarm), 32'(0));

        // Fill to full against a stalled sink; fifth sample must stay pending.
        thr     = 8'h00;
        rfd_out = 1'b0;
        send(8'h01, 1'b0, "full s1");
        send(8'h02, 1'b0, "full s2");
        send(8'h03, 1'b0, "full s3");
        send(8'h04, 1'b0, "full s4");
        chk("full level4", 32'(level), 32'(4));
        min  = 8'h05;
        dav_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full pending rfd", 32'(rfd), 32'(1));
            chk("full pending level", 32'(level), 32'(4));
        end
        rfd_out = 1'b1;
        step();
        chk("full pop data", 32'(data_out), 32'(8'h01));
        chk("full pop level", 32'(level), 32'(3));
        chk("full push blocked", 32'(rfd), 32'(1));
        step();
        chk("full late accept", 32'(rfd), 32'(0));
        chk("full late level", 32'(level), 32'(4));
        dav_ = 1'b1;
        recv(8'h01, "full r1");
        recv(8'h02, "full r2");
        recv(8'h03, "full r3");
        recv(8'h04, "full r4");
        recv(8'h05, "full r5");
        chk("full drained", 32'(level), 32'(0));

        // Push and pop on the same edge at level 2.
        rfd_out = 1'b0;
        send(8'h11, 1'b0, "sim s1");
        send(8'h22, 1'b0, "sim s2");
        chk("sim level2", 32'(level), 32'(2));
        min     = 8'h33;
        dav_    = 1'b0;
        rfd_out = 1'b1;
        step();
        chk("sim level kept", 32'(level), 32'(2));
        chk("sim accepted", 32'(rfd), 32'(0));
        chk("sim head", 32'(data_out), 32'(8'h11));
        dav_ = 1'b1;
        recv(8'h11, "sim r1");
        recv(8'h22, "sim r2");
        recv(8'h33, "sim r3");
        chk("sim drained", 32'(level), 32'(0));

        // Pointer wrap: ten samples through a responsive sink.
        for (int i = 0; i < 10; i += 2) begin
            send(8'hA0 + 8'(i), 1'b0, "wrap s");
            send(8'hA1 + 8'(i), 1'b0, "wrap s");
            recv(8'hA0 + 8'(i), "wrap r");
            recv(8'hA1 + 8'(i), "wrap r");
        end
        chk("wrap level", 32'(level), 32'(0));

        // Alarm sequence with thr = 0x40.
        thr = 8'h40;
        send(8'h30, 1'b0, "al 30a"); recv(8'h30, "al r");
        send(8'h3F, 1'b0, "al 3f");  recv(8'h3F, "al r");
        send(8'h10, 1'b1, "al 10");  recv(8'h10, "al r");
        send(8'h40, 1'b0, "al 40");  recv(8'h40, "al r");
        send(8'h30, 1'b0, "al 30b"); recv(8'h30, "al r");
        send(8'h30, 1'b0, "al 30c"); recv(8'h30, "al r");
        send(8'h20, 1'b1, "al 20a"); recv(8'h20, "al r");
        send(8'h20, 1'b1, "al 20b"); recv(8'h20, "al r");

        // Asynchronous reset in the middle of an upstream handshake.
        rfd_out = 1'b0;
        min     = 8'h05;
        dav_    = 1'b0;
        step();
        chk("mid accept", 32'(rfd), 32'(0));
        chk("mid level", 32'(level), 32'(1));
        chk("mid alarm", 32'(alarm), 32'(1));
        #2;
        reset_ = 1'b0;
        #1;
        chk("async rfd", 32'(rfd), 32'(1));
        chk("async dav_out_", 32'(dav_out_), 32'(1));
        chk("async data_out", 32'(data_out), 32'(0));
        chk("async level", 32'(level), 32'(0));
        chk("async alarm", 32'(alarm), 32'(0));
        dav_    = 1'b1;
        rfd_out = 1'b1;
        step();
        step();
        reset_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post reset dav_out_", 32'(dav_out_), 32'(1));
            chk("post reset level", 32'(level), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
